// File: rtl/passthrough_arb_pkg.sv
// Shared types and helpers for the passthrough cpuif arbiter.
//   state_e : arbiter FSM state (IDLE waiting for a request, BUSY with one
//             transfer outstanding downstream)
//   idx_w() : width of a requester index, never less than 1 bit so that a
//             single-requester build still has a legal vector
package passthrough_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_grant : index granted most recently; search starts one past it
//   grant      : one-hot winner (all zero when nothing requests)
//   grant_idx  : binary index of the winner
//   valid      : some requester won
module rr_arbiter
  import passthrough_arb_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             valid
);

  int idx;

  // Walk the requesters in rotated order; the first set bit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(last_grant) + 1 + k) % N_REQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/passthrough_cpuif_arbiter.sv
// Shares one passthrough cpuif master port between N_REQ requesters.
// Round-robin arbitration, one transfer outstanding at a time; the downstream
// ack/err/data is steered combinationally to the owning requester only.
//
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   s_req/s_req_is_wr   : per-requester request and direction
//   s_addr/s_wr_data    : flattened per-requester address / write data
//   s_grant             : one-cycle pulse, request accepted
//   s_rd_ack/s_rd_err   : read completion to owner, shared s_rd_data
//   s_wr_ack/s_wr_err   : write completion to owner
//   m_cpuif_*           : downstream passthrough cpuif (req is a 1-cycle pulse,
//                         addr/data/dir are zero whenever req is low)
//
// Build option: define PT_ARB_TIMEOUT_EN to force an error completion after
// TIMEOUT_CYCLES BUSY cycles without a matching ack. Without it BUSY waits
// forever and TIMEOUT_CYCLES only feeds the parameter sanity check.
module passthrough_cpuif_arbiter
  import passthrough_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            s_req,
  input  logic [N_REQ-1:0]            s_req_is_wr,
  input  logic [N_REQ*ADDR_WIDTH-1:0] s_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_wr_data,
  output logic [N_REQ-1:0]            s_grant,
  output logic [N_REQ-1:0]            s_rd_ack,
  output logic [N_REQ-1:0]            s_rd_err,
  output logic [DATA_WIDTH-1:0]       s_rd_data,
  output logic [N_REQ-1:0]            s_wr_ack,
  output logic [N_REQ-1:0]            s_wr_err,
  output logic                        m_cpuif_req,
  output logic                        m_cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0]       m_cpuif_addr,
  output logic [DATA_WIDTH-1:0]       m_cpuif_wr_data,
  input  logic                        m_cpuif_rd_ack,
  input  logic                        m_cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0]       m_cpuif_rd_data,
  input  logic                        m_cpuif_wr_ack,
  input  logic                        m_cpuif_wr_err
);

  localparam int IW = idx_w(N_REQ);

  state_e                  state_q, state_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [IW-1:0]           ptr_q, ptr_d;      // next search start index
  logic                    dir_q, dir_d;      // owner's direction, held for all of BUSY
  logic                    req_q, req_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [N_REQ-1:0]        grant_q, grant_d;

  logic [N_REQ-1:0]        arb_grant;
  logic [IW-1:0]           arb_idx;
  logic                    arb_valid;
  logic [IW-1:0]           rr_last;
  logic                    match_ack;
  logic                    to_hit;

  // The picker wants the last winner; ptr_q holds the slot after it.
  assign rr_last = (ptr_q == '0) ? IW'(N_REQ - 1) : ptr_q - IW'(1);

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (s_req),
    .last_grant (rr_last),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .valid      (arb_valid)
  );

  assign match_ack = (state_q == BUSY) && (dir_q ? m_cpuif_wr_ack : m_cpuif_rd_ack);

`ifdef PT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts BUSY cycles already elapsed, so the Nth BUSY cycle sees N-1.
  assign to_hit = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d  = (state_q == BUSY) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and capture. Capture registers load only on the grant edge
  // and fall back to zero, giving the zero-when-idle master outputs for free.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    dir_d   = dir_q;
    req_d   = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    grant_d = '0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = BUSY;
          owner_d = arb_idx;
          ptr_d   = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
          dir_d   = s_req_is_wr[arb_idx];
          req_d   = 1'b1;
          wr_d    = s_req_is_wr[arb_idx];
          addr_d  = s_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = s_wr_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          grant_d = arb_grant;
        end
      end
      BUSY: begin
        if (match_ack || to_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response steering. A real matching ack beats a timeout in the same cycle.
  always_comb begin
    s_rd_ack  = '0;
    s_rd_err  = '0;
    s_rd_data = '0;
    s_wr_ack  = '0;
    s_wr_err  = '0;
    if (state_q == BUSY) begin
      if (!dir_q && (m_cpuif_rd_ack || to_hit)) begin
        s_rd_ack[owner_q] = 1'b1;
        s_rd_err[owner_q] = m_cpuif_rd_ack ? m_cpuif_rd_err : 1'b1;
        if (m_cpuif_rd_ack) s_rd_data = m_cpuif_rd_data;
      end
      if (dir_q && (m_cpuif_wr_ack || to_hit)) begin
        s_wr_ack[owner_q] = 1'b1;
        s_wr_err[owner_q] = m_cpuif_wr_ack ? m_cpuif_wr_err : 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
    end
  end

  assign s_grant           = grant_q;
  assign m_cpuif_req       = req_q;
  assign m_cpuif_req_is_wr = wr_q;
  assign m_cpuif_addr      = addr_q;
  assign m_cpuif_wr_data   = wdata_q;

  // Simulation-only checks: an unknown request must never reach arbitration,
  // and the configuration must be in its supported range.
  always_ff @(posedge clk) begin
    if (rst && state_q == IDLE) assert (!$isunknown(s_req));
    assert (N_REQ >= 1 && N_REQ <= 16 && TIMEOUT_CYCLES >= 1);
  end

endmodule

// File: tb/tb_passthrough_cpuif_arbiter.sv
module tb_passthrough_cpuif_arbiter;

  localparam int N = 2, DW = 32, AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    s_req, s_req_is_wr, s_grant, s_rd_ack, s_rd_err, s_wr_ack, s_wr_err;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_wr_data;
  logic [DW-1:0]   s_rd_data, m_cpuif_wr_data, m_cpuif_rd_data;
  logic [AW-1:0]   m_cpuif_addr;
  logic            m_cpuif_req, m_cpuif_req_is_wr;
  logic            m_cpuif_rd_ack, m_cpuif_rd_err, m_cpuif_wr_ack, m_cpuif_wr_err;

  int n_cmp = 0;
  int n_bad = 0;

  passthrough_cpuif_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_req_is_wr(s_req_is_wr), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_grant(s_grant), .s_rd_ack(s_rd_ack), .s_rd_err(s_rd_err), .s_rd_data(s_rd_data),
    .s_wr_ack(s_wr_ack), .s_wr_err(s_wr_err),
    .m_cpuif_req(m_cpuif_req), .m_cpuif_req_is_wr(m_cpuif_req_is_wr),
    .m_cpuif_addr(m_cpuif_addr), .m_cpuif_wr_data(m_cpuif_wr_data),
    .m_cpuif_rd_ack(m_cpuif_rd_ack), .m_cpuif_rd_err(m_cpuif_rd_err),
    .m_cpuif_rd_data(m_cpuif_rd_data), .m_cpuif_wr_ack(m_cpuif_wr_ack),
    .m_cpuif_wr_err(m_cpuif_wr_err)
  );

  task automatic idle_inputs();
    s_req = '0; s_req_is_wr = '0; s_addr = '0; s_wr_data = '0;
    m_cpuif_rd_ack = 1'b0; m_cpuif_rd_err = 1'b0; m_cpuif_rd_data = '0;
    m_cpuif_wr_ack = 1'b0; m_cpuif_wr_err = 1'b0;
  endtask

  // Ends on a negedge with rst released; the next posedge is the first live one.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    s_req = 2'b11; m_cpuif_rd_ack = 1'b1; m_cpuif_wr_ack = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", s_grant); end
    n_cmp++; if (m_cpuif_req !== 1'b0) begin n_bad++; $display("FAIL reset_mreq: got %b want 0", m_cpuif_req); end
    n_cmp++; if (m_cpuif_addr !== 32'h0 || m_cpuif_wr_data !== 32'h0 || m_cpuif_req_is_wr !== 1'b0) begin
      n_bad++; $display("FAIL reset_mregs: addr %h data %h wr %b want all 0", m_cpuif_addr, m_cpuif_wr_data, m_cpuif_req_is_wr); end
    n_cmp++; if (s_rd_ack !== 2'b00 || s_wr_ack !== 2'b00) begin
      n_bad++; $display("FAIL reset_acks: rd %b wr %b want 00 00", s_rd_ack, s_wr_ack); end
    idle_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    s_req = 2'b01; s_req_is_wr = 2'b01; s_addr[31:0] = 32'h10; s_wr_data[31:0] = 32'hA5A5A5A5;
    @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b01) begin n_bad++; $display("FAIL wr_grant: got %b want 01", s_grant); end
    n_cmp++; if (m_cpuif_req !== 1'b1 || m_cpuif_req_is_wr !== 1'b1) begin
      n_bad++; $display("FAIL wr_mreq: req %b wr %b want 1 1", m_cpuif_req, m_cpuif_req_is_wr); end
    n_cmp++; if (m_cpuif_addr !== 32'h10 || m_cpuif_wr_data !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL wr_mpayload: addr %h data %h want 00000010 a5a5a5a5", m_cpuif_addr, m_cpuif_wr_data); end
    s_req = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (m_cpuif_req !== 1'b0 || m_cpuif_addr !== 32'h0 || m_cpuif_wr_data !== 32'h0 || m_cpuif_req_is_wr !== 1'b0) begin
      n_bad++; $display("FAIL wr_mreq_pulse: req %b addr %h data %h wr %b want all 0", m_cpuif_req, m_cpuif_addr, m_cpuif_wr_data, m_cpuif_req_is_wr); end
    n_cmp++; if (s_grant !== 2'b00 || s_wr_ack !== 2'b00) begin
      n_bad++; $display("FAIL wr_wait: grant %b wr_ack %b want 00 00", s_grant, s_wr_ack); end
    @(negedge clk);
    @(negedge clk); m_cpuif_wr_ack = 1'b1; #1;
    n_cmp++; if (s_wr_ack !== 2'b01 || s_wr_err !== 2'b00) begin
      n_bad++; $display("FAIL wr_ack_route: ack %b err %b want 01 00", s_wr_ack, s_wr_err); end
    // FSM is back in IDLE here, so this second ack must be dropped.
    @(negedge clk); #1;
    n_cmp++; if (s_wr_ack !== 2'b00) begin n_bad++; $display("FAIL wr_ack_idle: got %b want 00", s_wr_ack); end
    m_cpuif_wr_ack = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    s_req = 2'b11; s_req_is_wr = 2'b00; s_addr = {32'h200, 32'h100};
    @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b01 || m_cpuif_addr !== 32'h100) begin
      n_bad++; $display("FAIL cont_first: grant %b addr %h want 01 00000100", s_grant, m_cpuif_addr); end
    s_req = 2'b10;
    @(negedge clk); m_cpuif_rd_ack = 1'b1; m_cpuif_rd_data = 32'h11111111; #1;
    n_cmp++; if (s_rd_ack !== 2'b01 || s_rd_data !== 32'h11111111) begin
      n_bad++; $display("FAIL cont_rd0: ack %b data %h want 01 11111111", s_rd_ack, s_rd_data); end
    @(negedge clk); m_cpuif_rd_ack = 1'b0; m_cpuif_rd_data = 32'h33333333; #1;
    n_cmp++; if (s_grant !== 2'b00 || s_rd_data !== 32'h0) begin
      n_bad++; $display("FAIL cont_gap: grant %b data %h want 00 00000000", s_grant, s_rd_data); end
    @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b10 || m_cpuif_addr !== 32'h200) begin
      n_bad++; $display("FAIL cont_second: grant %b addr %h want 10 00000200", s_grant, m_cpuif_addr); end
    s_req = 2'b00;
    @(negedge clk); m_cpuif_rd_ack = 1'b1; m_cpuif_rd_data = 32'h22222222; #1;
    n_cmp++; if (s_rd_ack !== 2'b10 || s_rd_data !== 32'h22222222) begin
      n_bad++; $display("FAIL cont_rd1: ack %b data %h want 10 22222222", s_rd_ack, s_rd_data); end
    @(negedge clk); m_cpuif_rd_ack = 1'b0; m_cpuif_rd_data = '0;
  endtask

  task automatic test_fairness();
    int exp_idx [6];
    int got;
    int c1;
    exp_idx = '{0, 1, 0, 1, 0, 1};
    got = 0; c1 = 0;
    do_reset();
    s_req = 2'b11; s_req_is_wr = 2'b00;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk); m_cpuif_rd_ack = 1'b0; #1;
      if (s_grant !== 2'b00) begin
        n_cmp++; if (s_grant !== N'(1 << exp_idx[got])) begin
          n_bad++; $display("FAIL fair_order[%0d]: got %b want %b", got, s_grant, N'(1 << exp_idx[got])); end
        if (s_grant[1]) c1++;
        if (c1 == 3) s_req[1] = 1'b0;
        m_cpuif_rd_ack = 1'b1; #1;
        n_cmp++; if (s_rd_ack !== N'(1 << exp_idx[got])) begin
          n_bad++; $display("FAIL fair_ack[%0d]: got %b want %b", got, s_rd_ack, N'(1 << exp_idx[got])); end
        got++;
      end
    end
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL fair_count: got %0d grants want 6", got); end
    s_req = 2'b00;
    @(negedge clk); m_cpuif_rd_ack = 1'b0;
  endtask

  task automatic test_same_cycle_ack();
    do_reset();
    s_req = 2'b10; s_req_is_wr = 2'b00; s_addr = {32'h300, 32'h0};
    @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b10) begin n_bad++; $display("FAIL sca_grant: got %b want 10", s_grant); end
    m_cpuif_rd_ack = 1'b1; m_cpuif_rd_err = 1'b1; m_cpuif_rd_data = 32'hDEADBEEF; #1;
    n_cmp++; if (s_rd_ack !== 2'b10 || s_rd_err !== 2'b10 || s_rd_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sca_resp: ack %b err %b data %h want 10 10 deadbeef", s_rd_ack, s_rd_err, s_rd_data); end
    // IDLE cycle: stray acks of both kinds must not be forwarded.
    @(negedge clk); m_cpuif_rd_err = 1'b0; m_cpuif_wr_ack = 1'b1; #1;
    n_cmp++; if (s_grant !== 2'b00 || s_rd_ack !== 2'b00 || s_wr_ack !== 2'b00) begin
      n_bad++; $display("FAIL sca_idle: grant %b rd %b wr %b want 00 00 00", s_grant, s_rd_ack, s_wr_ack); end
    @(negedge clk); m_cpuif_rd_ack = 1'b0; m_cpuif_wr_ack = 1'b0; #1;
    n_cmp++; if (s_grant !== 2'b10) begin n_bad++; $display("FAIL sca_regrant: got %b want 10", s_grant); end
    s_req = 2'b00;
    m_cpuif_wr_ack = 1'b1; #1;
    n_cmp++; if (s_rd_ack !== 2'b00 || s_wr_ack !== 2'b00) begin
      n_bad++; $display("FAIL sca_wrongtype: rd %b wr %b want 00 00", s_rd_ack, s_wr_ack); end
    @(negedge clk); m_cpuif_wr_ack = 1'b0; m_cpuif_rd_ack = 1'b1; m_cpuif_rd_data = 32'h0BADF00D; #1;
    n_cmp++; if (s_rd_ack !== 2'b10 || s_rd_err !== 2'b00 || s_rd_data !== 32'h0BADF00D) begin
      n_bad++; $display("FAIL sca_late: ack %b err %b data %h want 10 00 0badf00d", s_rd_ack, s_rd_err, s_rd_data); end
    @(negedge clk); m_cpuif_rd_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_req = 2'b01; s_req_is_wr = 2'b01; s_addr = {32'h0, 32'h40}; s_wr_data = {32'h0, 32'h12345678};
    @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b01) begin n_bad++; $display("FAIL rmid_grant: got %b want 01", s_grant); end
    s_req = 2'b00;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1; m_cpuif_wr_ack = 1'b1;
    s_req = 2'b11; s_req_is_wr = 2'b00; s_addr = {32'h80, 32'h70}; #1;
    n_cmp++; if (s_wr_ack !== 2'b00) begin n_bad++; $display("FAIL rmid_lateack: got %b want 00", s_wr_ack); end
    n_cmp++; if (m_cpuif_req !== 1'b0 || s_grant !== 2'b00 || m_cpuif_addr !== 32'h0) begin
      n_bad++; $display("FAIL rmid_outs: req %b grant %b addr %h want 0 00 0", m_cpuif_req, s_grant, m_cpuif_addr); end
    @(negedge clk); m_cpuif_wr_ack = 1'b0; #1;
    n_cmp++; if (s_grant !== 2'b01 || m_cpuif_addr !== 32'h70) begin
      n_bad++; $display("FAIL rmid_next: grant %b addr %h want 01 00000070", s_grant, m_cpuif_addr); end
    s_req = 2'b00;
  endtask

`ifdef PT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    s_req = 2'b01; s_req_is_wr = 2'b00; m_cpuif_rd_data = 32'hFFFFFFFF;
    @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b01) begin n_bad++; $display("FAIL to_grant: got %b want 01", s_grant); end
    s_req = 2'b00;
    repeat (6) @(negedge clk); #1;
    n_cmp++; if (s_rd_ack !== 2'b00) begin n_bad++; $display("FAIL to_early: got %b want 00", s_rd_ack); end
    @(negedge clk); #1;
    n_cmp++; if (s_rd_ack !== 2'b01 || s_rd_err !== 2'b01 || s_rd_data !== 32'h0) begin
      n_bad++; $display("FAIL to_fire: ack %b err %b data %h want 01 01 0", s_rd_ack, s_rd_err, s_rd_data); end
    s_req = 2'b10;
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b10) begin n_bad++; $display("FAIL to_next: got %b want 10", s_grant); end
    s_req = 2'b00;
    m_cpuif_rd_ack = 1'b1;
    @(negedge clk); m_cpuif_rd_ack = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    s_req = 2'b01; s_req_is_wr = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b01) begin n_bad++; $display("FAIL nto_grant: got %b want 01", s_grant); end
    s_req = 2'b10;
    repeat (20) @(negedge clk); #1;
    n_cmp++; if (s_rd_ack !== 2'b00 || s_grant !== 2'b00) begin
      n_bad++; $display("FAIL nto_wait: ack %b grant %b want 00 00", s_rd_ack, s_grant); end
    m_cpuif_rd_ack = 1'b1; #1;
    n_cmp++; if (s_rd_ack !== 2'b01) begin n_bad++; $display("FAIL nto_ack: got %b want 01", s_rd_ack); end
    @(negedge clk); m_cpuif_rd_ack = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (s_grant !== 2'b10) begin n_bad++; $display("FAIL nto_next: got %b want 10", s_grant); end
    s_req = 2'b00;
    m_cpuif_rd_ack = 1'b1;
    @(negedge clk); m_cpuif_rd_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_fairness();
    test_same_cycle_ack();
    test_reset_mid();
`ifdef PT_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
